// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 6x6 multiplier among NREQ requesters.
// Optional issued-operation counter is built when MUL_ARBITER_STATS_EN is defined.
module mul_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [6*NREQ-1:0]    req_a,
   input  logic [6*NREQ-1:0]    req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [13*NREQ-1:0]   rsp_data,
   output logic [5:0]           mul_a,
   output logic [5:0]           mul_b,
   input  logic [12:0]          mul_p,
   output logic                 busy,
   output logic [15:0]          op_count
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned D  = MUL_LAT + 1;

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      INFLIGHT = 2'd1,
      DONE     = 2'd2
   } slot_t;

   slot_t              slot_q [NREQ];
   slot_t              slot_d [NREQ];
   logic [PW-1:0]      rr_q, rr_d;
   logic [D-1:0]       tag_vld_q;
   logic [PW-1:0]      tag_id_q [D];
   logic [5:0]         mul_a_q, mul_b_q;
   logic [13*NREQ-1:0] rsp_data_q;
   logic               grant_vld;
   logic [PW-1:0]      grant_id;
   logic               cap_vld;
   logic [PW-1:0]      cap_id;

   // First eligible index at or above rr_q, wrapping modulo NREQ.
   always_comb begin
      int unsigned   idx;
      logic [PW-1:0] ix;
      idx       = 0;
      ix        = '0;
      grant_vld = 1'b0;
      grant_id  = '0;
      req_ready = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx = (32'(rr_q) + off) % NREQ;
         ix  = PW'(idx);
         if (!grant_vld && req_valid[ix] && (slot_q[ix] == FREE)) begin
            grant_vld = 1'b1;
            grant_id  = ix;
         end
      end
      if (grant_vld) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (grant_vld) begin
         rr_d = (grant_id == PW'(NREQ - 1)) ? '0 : grant_id + PW'(1);
      end
   end

   assign cap_vld = tag_vld_q[D-1];
   assign cap_id  = tag_id_q[D-1];

   always_comb begin
      busy = |tag_vld_q;
      for (int unsigned k = 0; k < NREQ; k++) begin
         slot_d[k]    = slot_q[k];
         rsp_valid[k] = (slot_q[k] == DONE);
         if (slot_q[k] != FREE) begin
            busy = 1'b1;
         end
         case (slot_q[k])
            FREE:     if (grant_vld && (grant_id == PW'(k))) slot_d[k] = INFLIGHT;
            INFLIGHT: if (cap_vld && (cap_id == PW'(k)))     slot_d[k] = DONE;
            DONE:     if (rsp_ready[k])                      slot_d[k] = FREE;
            default:  slot_d[k] = FREE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q       <= '0;
         tag_vld_q  <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         rsp_data_q <= '0;
         for (int unsigned d = 0; d < D; d++) begin
            tag_id_q[d] <= '0;
         end
         for (int unsigned k = 0; k < NREQ; k++) begin
            slot_q[k] <= FREE;
         end
      end else begin
         rr_q        <= rr_d;
         tag_vld_q   <= {tag_vld_q[D-2:0], grant_vld};
         tag_id_q[0] <= grant_id;
         for (int unsigned d = 1; d < D; d++) begin
            tag_id_q[d] <= tag_id_q[d-1];
         end
         if (grant_vld) begin
            mul_a_q <= req_a[6*grant_id +: 6];
            mul_b_q <= req_b[6*grant_id +: 6];
         end
         // Tag leaving the last stage lines up with the product now on mul_p.
         for (int unsigned k = 0; k < NREQ; k++) begin
            if (cap_vld && (cap_id == PW'(k))) begin
               rsp_data_q[13*k +: 13] <= mul_p;
            end
            slot_q[k] <= slot_d[k];
         end
      end
   end

   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;
   assign rsp_data = rsp_data_q;

`ifdef MUL_ARBITER_STATS_EN
   logic [15:0] op_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt_q <= '0;
      end else if (grant_vld && (op_cnt_q != '1)) begin
         op_cnt_q <= op_cnt_q + 16'd1;
      end
   end

   assign op_count = op_cnt_q;
`else
   assign op_count = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a two-stage behavioural multiplier.
module tb_mul_arbiter;

   localparam int unsigned NREQ = 4;
`ifdef MUL_ARBITER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [6*NREQ-1:0]  req_a;
   logic [6*NREQ-1:0]  req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [13*NREQ-1:0] rsp_data;
   logic [5:0]         mul_a;
   logic [5:0]         mul_b;
   logic [12:0]        mul_p;
   logic               busy;
   logic [15:0]        op_count;

   int n_checks = 0;
   int n_errors = 0;

   mul_arbiter #(.NREQ(NREQ), .MUL_LAT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_p     (mul_p),
      .busy      (busy),
      .op_count  (op_count)
   );

   // Registered inputs, registered product, no reset.
   logic [5:0] ra, rb;
   always_ff @(posedge clk) begin
      ra    <= mul_a;
      rb    <= mul_b;
      mul_p <= 13'(ra) * 13'(rb);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      req_a[6*i +: 6] = 6'(a);
      req_b[6*i +: 6] = 6'(b);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  t2_rdy [8];
      logic [3:0]  t2_vld [8];
      logic [12:0] t2_dat [4];
      logic [3:0]  t4_rdy [12];
      int cnt0, cnt2, cnt3;

      t2_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      t2_vld = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      t2_dat = '{13'd3, 13'd10, 13'd21, 13'd36};
      t4_rdy = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};

      rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
      do_reset;

      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data",  rsp_data, 0);
      check("rst_mul_a",     mul_a, 0);
      check("rst_mul_b",     mul_b, 0);
      check("rst_busy",      busy, 0);
      check("rst_op_count",  op_count, 0);

      // Single op, latency, hold under backpressure, release
      set_ops(0, 63, 63);
      req_valid = 4'b0001;
      #1 check("t1_grant", req_ready, 4'b0001);
      tick;
      check("t1_mul_a", mul_a, 63);
      check("t1_mul_b", mul_b, 63);
      check("t1_busy",  busy, 1);
      for (int c = 1; c <= 3; c++) begin
         #1;
         check("t1_inflight_rdy", req_ready, 0);
         check("t1_inflight_vld", rsp_valid, 0);
         tick;
      end
      check("t1_vld", rsp_valid, 4'b0001);
      check("t1_data", rsp_data[12:0], 3969);
      repeat (5) begin
         tick;
         check("t1_hold_vld",  rsp_valid, 4'b0001);
         check("t1_hold_data", rsp_data[12:0], 3969);
         check("t1_hold_rdy",  req_ready, 0);
      end
      rsp_ready = 4'b0001;
      #1 check("t1_hs_no_grant", req_ready, 0);
      tick;
      rsp_ready = '0;
      #1;
      check("t1_vld_drop", rsp_valid, 0);
      check("t1_regrant", req_ready, 4'b0001);
      req_valid = '0;
      tick;
      check("t1_idle_busy", busy, 0);
      check("t1_op_count", op_count, STATS ? 1 : 0);

      // Contention from reset
      do_reset;
      for (int i = 0; i < 4; i++) set_ops(i, i + 1, 2 * i + 3);
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         check("t2_grant", req_ready, t2_rdy[c]);
         check("t2_vld",   rsp_valid, t2_vld[c]);
         tick;
      end
      for (int i = 0; i < 4; i++) check("t2_data", rsp_data[13*i +: 13], t2_dat[i]);
      req_valid = '0;
      rsp_ready = 4'b1111;
      tick;
      rsp_ready = '0;
      #1;
      check("t2_drain_vld", rsp_valid, 0);
      check("t2_drain_busy", busy, 0);
      check("t2_op_count", op_count, STATS ? 4 : 0);

      // Requester 1 withholds rsp_ready
      do_reset;
      for (int i = 0; i < 4; i++) set_ops(i, i + 2, 3);
      req_valid = 4'b1111;
      rsp_ready = 4'b1101;
      cnt0 = 0; cnt2 = 0; cnt3 = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (req_ready[0]) cnt0++;
         if (req_ready[2]) cnt2++;
         if (req_ready[3]) cnt3++;
         if (c >= 2) check("t3_no_regrant1", req_ready[1], 0);
         tick;
      end
      check("t3_cnt0", cnt0, 4);
      check("t3_cnt2", cnt2, 4);
      check("t3_cnt3", cnt3, 4);
      req_valid = 4'b0010;
      repeat (6) tick;
      check("t3_vld1",  rsp_valid, 4'b0010);
      check("t3_data1", rsp_data[13 +: 13], 9);
      rsp_ready = 4'b1111;
      #1 check("t3_hs_no_grant", req_ready, 0);
      tick;
      rsp_ready = 4'b1101;
      #1;
      check("t3_regrant1", req_ready, 4'b0010);
      check("t3_vld_drop", rsp_valid, 0);
      tick;
      req_valid = '0;
      repeat (3) tick;
      check("t3_vld1_again",  rsp_valid, 4'b0010);
      check("t3_data1_again", rsp_data[13 +: 13], 9);
      rsp_ready = 4'b1111;
      tick;
      check("t3_idle_busy", busy, 0);

      // Fairness between requesters 0 and 2
      do_reset;
      req_valid = 4'b0101;
      rsp_ready = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         #1 check("t4_grant", req_ready, t4_rdy[c]);
         tick;
      end
      req_valid = '0;
      repeat (6) tick;
      check("t4_idle_busy", busy, 0);

      // Reset while an op is in flight
      do_reset;
      set_ops(3, 5, 7);
      req_valid = 4'b1000;
      #1 check("t5_grant", req_ready, 4'b1000);
      tick;
      req_valid = '0;
      tick;
      rst = 1'b1;
      #1;
      check("t5_busy", busy, 0);
      check("t5_op_count", op_count, 0);
      check("t5_vld", rsp_valid, 0);
      check("t5_mul_a", mul_a, 0);
      tick;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1 check("t5_no_rsp", rsp_valid, 0);
         tick;
      end

`ifdef MUL_ARBITER_STATS_EN
      begin
         int acc;
         int cyc;
         do_reset;
         req_valid = 4'b1111;
         rsp_ready = 4'b1111;
         acc = 0; cyc = 0;
         while (acc < 10 && cyc < 200) begin
            #1;
            if (req_ready != 0) acc++;
            tick;
            cyc++;
         end
         req_valid = '0;
         check("t6_10_in_time", cyc < 200, 1);
         check("t6_count10", op_count, 10);
         req_valid = 4'b1111;
         cyc = 0;
         while (acc < 65540 && cyc < 90000) begin
            #1;
            if (req_ready != 0) acc++;
            tick;
            cyc++;
         end
         req_valid = '0;
         check("t6_sat_in_time", cyc < 90000, 1);
         check("t6_saturate", op_count, 16'hFFFF);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one pipelined 6x6 Wallace multiplier (registered inputs, registered 13-bit product) between NREQ requesters.
- Round-robin grant, one operation issued per cycle.
- Each product is tagged with its requester id and returned to a per-requester result slot with a valid/ready handshake.
- Sits between the requesting datapath units and the multiplier instance, which it drives directly.

Parameters:
NREQ, 4, number of requesters (2..8)
MUL_LAT, 2, clock edges from multiplier operand input to registered product output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  NREQ  requester i has operands ready
req_ready  output  NREQ  grant; one-hot or zero, combinational
req_a  input  6*NREQ  operand A, requester i at bits [6i+5:6i]
req_b  input  6*NREQ  operand B, same packing
rsp_valid  output  NREQ  result slot i holds a product
rsp_ready  input  NREQ  requester i consumes its result
rsp_data  output  13*NREQ  product for requester i at bits [13i+12:13i]
mul_a  output  6  registered operand A to multiplier
mul_b  output  6  registered operand B to multiplier
mul_p  input  13  registered product from multiplier
busy  output  1  any slot not FREE, or tag pipe non-empty
op_count  output  16  issued-operation counter (see Optional Feature)

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, busy=0, op_count=0; all slots FREE; tag pipe cleared; rr_ptr=0.
- Slot FSM per requester: FREE -> INFLIGHT on accept; INFLIGHT -> DONE when its tag exits the pipe; DONE -> FREE on rsp_valid&rsp_ready. No other transitions.
- Limit: one outstanding operation per requester.
- Eligibility: eligible[i] = req_valid[i] && slot[i]==FREE.
- Arbitration: search from rr_ptr upward, modulo NREQ. The first eligible index g gets req_ready[g]=1 in the same cycle. req_ready depends on req_valid.
- No eligible requester: req_ready=0, nothing issued, rr_ptr held.
- On accept (edge E0): mul_a<=req_a[g], mul_b<=req_b[g]; tag stage0<={1,g}; rr_ptr<=(g+1) mod NREQ.
- Cycles with no accept: mul_a/mul_b hold their value; stage0 valid<=0.
- Tag pipe: depth D=1+MUL_LAT, shifts every cycle, no stall.
- Capture: when stage D-1 is valid with id k, at the next edge rsp_data[k]<=mul_p, slot[k]<=DONE, rsp_valid[k]<=1.
- Latency: accept in cycle t gives rsp_valid from cycle t+MUL_LAT+2 (t+4 at default). Throughput is 1 op/cycle across distinct requesters.
- rsp_data[k] is stable while rsp_valid[k]=1. rsp_valid drops the edge after the handshake.
- A requester's slot is FREE one cycle after its response handshake. A new req_valid in the handshake cycle is not granted until the next cycle.
- Pipe cannot overflow or collide: the one-outstanding rule guarantees at most one tag per id, so no capture collision.
- Reset mid-operation: all tags discarded, slots FREE, pending results lost. The multiplier has no reset and its stale product is ignored because the tags are invalid.
- busy = OR over (slot!=FREE) OR any tag valid.
- Arithmetic: none in this block beyond the rr_ptr wrap; the product is passed through unmodified.

Optional Feature:
- Macro MUL_ARBITER_STATS_EN.
- Defined: op_count increments by 1 on every accept and saturates at 16'hFFFF; cleared only by rst.
- Undefined: op_count is tied to 0 and no counter logic is built.

Test Plan:
- Single op: after reset, req_valid[0]=1, a=63, b=63 accepted in cycle t -> rsp_valid[0]=1 in cycle t+4 with rsp_data[0]=3969. Hold rsp_ready=0 five cycles -> data stable; pulse rsp_ready -> rsp_valid[0]=0 next cycle.
- Contention: all four req_valid=1 in the same cycle, operands (i+1, 2i+3) -> grants 0,1,2,3 on consecutive cycles; results 3,10,21,36 on rsp_valid 0..3 in consecutive cycles.
- Backpressure: requester 1 keeps rsp_ready=0 with a new request pending -> never re-granted. Requesters 0, 2 and 3 keep issuing each in turn; requester 1 is granted the cycle after its handshake.
- Fairness: req 0 and 2 continuously valid, rsp_ready tied 1 -> grants alternate 0,2,0,2; neither is starved.
- Reset mid-flight: assert rst two cycles after accepting requester 3 (a=5, b=7) -> rsp_valid[3] never rises, busy=0 and op_count=0 immediately after rst.
- Stats (MUL_ARBITER_STATS_EN): 10 accepts -> op_count=10. Forced 65540 accepts -> op_count=65535. With the macro undefined, op_count=0 throughout.
